// File: rtl/truth_table_reader.sv
// ---------------------------------------------------------------------------
// truth_table_reader
//
// Characterises a 3-input combinational block. It drives the eight input
// vectors in turn, holding each one for SETTLE_CYCLES clocks. At the end of
// each hold period it samples the block's output. From the eight samples it
// rebuilds the 8-bit function code and compares that code with an expected
// code.
//
// Code convention: idx = {in1,in2,in3}. Bit (7-idx) of the code is the
// block's output for vector idx. For example, an output that is high only
// at idx 5 and idx 6 gives the code 8'h06.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   CNT_W          width of the settle counter (2**CNT_W >= SETTLE_CYCLES)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          scan request, accepted only while idle
//   abort          abandons a scan in progress; ignored while idle
//   expected       expected function code, latched when start is accepted
//   dut_out        output of the block being measured (same clock domain)
//   in1/in2/in3    block inputs: MSB, middle bit and LSB of the vector index
//   busy           high while a scan is in progress
//   done           one-cycle pulse when a scan completes
//   table_out      reconstructed function code of the last completed scan
//   match          table_out equals the latched expected code
//   mismatch_mask  table_out XOR latched expected code
// ---------------------------------------------------------------------------
module truth_table_reader #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   input  logic       dut_out,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
   output logic       match,
   output logic [7:0] mismatch_mask
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // The final count of a hold period. The sample is taken on the edge
   // where the counter holds this value.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Returns the table with bit (7-idx) replaced by the sampled value.
   function automatic logic [7:0] insert_sample(
      input logic [7:0] tab,
      input logic [2:0] idx,
      input logic       value
   );
      logic [7:0] res;
      res              = tab;
      res[3'd7 - idx]  = value;
      return res;
   endfunction

   state_t           state_r, state_n;
   logic [2:0]       idx_r, idx_n;
   logic [CNT_W-1:0] cnt_r, cnt_n;
   logic [7:0]       shadow_r, shadow_n;
   logic [7:0]       exp_r, exp_n;
   logic [2:0]       bus_r, bus_n;
   logic             busy_r, busy_n;
   logic             done_r, done_n;
   logic [7:0]       table_r, table_n;
   logic             match_r, match_n;
   logic [7:0]       mask_r, mask_n;
   logic [7:0]       sampled_s;

   // Next-state and next-output logic for the scan sequencer.
   always_comb begin
      state_n   = state_r;
      idx_n     = idx_r;
      cnt_n     = cnt_r;
      shadow_n  = shadow_r;
      exp_n     = exp_r;
      bus_n     = bus_r;
      busy_n    = busy_r;
      done_n    = 1'b0;
      table_n   = table_r;
      match_n   = match_r;
      mask_n    = mask_r;
      sampled_s = insert_sample(shadow_r, idx_r, dut_out);

      case (state_r)
         IDLE: begin
            busy_n = 1'b0;
            bus_n  = 3'b000;
            cnt_n  = {CNT_W{1'b0}};
            if (start) begin
               state_n  = SETTLE;
               idx_n    = 3'd0;
               busy_n   = 1'b1;
               exp_n    = expected;
               shadow_n = 8'h00;
            end else begin
               state_n = IDLE;
            end
         end

         SETTLE: begin
            // abort takes priority, even over the final sample edge.
            if (abort) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               bus_n   = 3'b000;
               cnt_n   = {CNT_W{1'b0}};
               idx_n   = 3'd0;
            end else if (cnt_r == CNT_LAST) begin
               shadow_n = sampled_s;
               cnt_n    = {CNT_W{1'b0}};
               if (idx_r == 3'd7) begin
                  // The results use sampled_s so that they include this
                  // final sample.
                  state_n = DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  bus_n   = 3'b000;
                  table_n = sampled_s;
                  match_n = (sampled_s == exp_r);
                  mask_n  = sampled_s ^ exp_r;
               end else begin
                  idx_n = idx_r + 3'd1;
                  bus_n = idx_r + 3'd1;
               end
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end

         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            bus_n   = 3'b000;
            cnt_n   = {CNT_W{1'b0}};
         end

         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            bus_n   = 3'b000;
            cnt_n   = {CNT_W{1'b0}};
            idx_n   = 3'd0;
         end
      endcase
   end

   // State and output registers; every output is driven directly from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         idx_r    <= 3'd0;
         cnt_r    <= {CNT_W{1'b0}};
         shadow_r <= 8'h00;
         exp_r    <= 8'h00;
         bus_r    <= 3'b000;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         table_r  <= 8'h00;
         match_r  <= 1'b0;
         mask_r   <= 8'h00;
      end else begin
         state_r  <= state_n;
         idx_r    <= idx_n;
         cnt_r    <= cnt_n;
         shadow_r <= shadow_n;
         exp_r    <= exp_n;
         bus_r    <= bus_n;
         busy_r   <= busy_n;
         done_r   <= done_n;
         table_r  <= table_n;
         match_r  <= match_n;
         mask_r   <= mask_n;
      end
   end

   assign in1           = bus_r[2];
   assign in2           = bus_r[1];
   assign in3           = bus_r[0];
   assign busy          = busy_r;
   assign done          = done_r;
   assign table_out     = table_r;
   assign match         = match_r;
   assign mismatch_mask = mask_r;

endmodule

// File: tb/tb_truth_table_reader.sv
// ---------------------------------------------------------------------------
// tb_truth_table_reader
//
// Bench for two instances of truth_table_reader:
//   u0  SETTLE_CYCLES = 4
//   u1  SETTLE_CYCLES = 1
// Each instance measures its own behavioural function code (fn0, fn1).
//
// The reference model is a scan in progress, described by a count k of the
// edges since start was accepted. The vector on the bus is k / S. A sample
// lands whenever k reaches a multiple of S.
// ---------------------------------------------------------------------------
module tb_truth_table_reader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
   logic [7:0] exp0 = 8'h00, exp1 = 8'h00;
   logic [7:0] fn0 = 8'h06, fn1 = 8'h69;
   logic       dut_out0, dut_out1;
   logic       in1_0, in2_0, in3_0, busy0, done0, match0;
   logic       in1_1, in2_1, in3_1, busy1, done1, match1;
   logic [7:0] tab0, mask0, tab1, mask1;

   // The measured blocks: the output for vector v is bit (7-v) of the code.
   assign dut_out0 = fn0[3'd7 - {in1_0, in2_0, in3_0}];
   assign dut_out1 = fn1[3'd7 - {in1_1, in2_1, in3_1}];

   truth_table_reader #(.SETTLE_CYCLES(4), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
      .expected(exp0), .dut_out(dut_out0),
      .in1(in1_0), .in2(in2_0), .in3(in3_0), .busy(busy0), .done(done0),
      .table_out(tab0), .match(match0), .mismatch_mask(mask0));

   truth_table_reader #(.SETTLE_CYCLES(1), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .expected(exp1), .dut_out(dut_out1),
      .in1(in1_1), .in2(in2_1), .in3(in3_1), .busy(busy1), .done(done1),
      .table_out(tab1), .match(match1), .mismatch_mask(mask1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      bit         act;
      bit         dn;
      int         k;
      logic [7:0] ex;
      logic [7:0] sh;
      logic [7:0] tab;
      bit         m;
      logic [7:0] mm;
   } mdl_t;

   mdl_t md0, md1;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.act = 1'b0; r.dn = 1'b0; r.k = 0;
      r.ex = 8'h00; r.sh = 8'h00; r.tab = 8'h00; r.m = 1'b0; r.mm = 8'h00;
      return r;
   endfunction

   function automatic mdl_t step(input mdl_t m, input int s, input bit st, input bit ab,
                                 input logic [7:0] ex, input logic [7:0] f);
      mdl_t n;
      int   v;
      n = m;
      if (m.dn) begin
         n.dn = 1'b0;
      end else if (!m.act) begin
         if (st) begin
            n.act = 1'b1; n.k = 0; n.ex = ex; n.sh = 8'h00;
         end
      end else if (ab) begin
         n.act = 1'b0;
      end else begin
         n.k = m.k + 1;
         if (n.k % s == 0) begin
            v = n.k / s - 1;
            n.sh[7 - v] = f[7 - v];
            if (v == 7) begin
               n.act = 1'b0;
               n.dn  = 1'b1;
               n.tab = n.sh;
               n.m   = (n.sh == n.ex);
               n.mm  = n.sh ^ n.ex;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [2:0] mdl_bus(input mdl_t m, input int s);
      return m.act ? 3'(m.k / s) : 3'b000;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md0 <= mdl_reset();
         md1 <= mdl_reset();
      end else begin
         md0 <= step(md0, 4, start0, abort0, exp0, fn0);
         md1 <= step(md1, 1, start1, abort1, exp1, fn1);
      end
   end

   // Compare process: every output of both instances is checked against the model on each falling edge.
   always @(negedge clk) begin
      chk("u0_bus",   {29'd0, in1_0, in2_0, in3_0}, {29'd0, mdl_bus(md0, 4)});
      chk("u0_busy",  {31'd0, busy0},  {31'd0, md0.act});
      chk("u0_done",  {31'd0, done0},  {31'd0, md0.dn});
      chk("u0_table", {24'd0, tab0},   {24'd0, md0.tab});
      chk("u0_match", {31'd0, match0}, {31'd0, md0.m});
      chk("u0_mask",  {24'd0, mask0},  {24'd0, md0.mm});
      chk("u1_bus",   {29'd0, in1_1, in2_1, in3_1}, {29'd0, mdl_bus(md1, 1)});
      chk("u1_busy",  {31'd0, busy1},  {31'd0, md1.act});
      chk("u1_done",  {31'd0, done1},  {31'd0, md1.dn});
      chk("u1_table", {24'd0, tab1},   {24'd0, md1.tab});
      chk("u1_match", {31'd0, match1}, {31'd0, md1.m});
      chk("u1_mask",  {24'd0, mask1},  {24'd0, md1.mm});
   end

   // ---------------- directed helpers ----------------
   // Pulse start. Then count the edges after the accepting edge (edge 0)
   // until done is observed.
   task automatic scan(input int i, input logic [7:0] e, input int req_edges);
      int edges;
      @(negedge clk);
      if (i == 0) begin start0 = 1'b1; exp0 = e; end
      else        begin start1 = 1'b1; exp1 = e; end
      @(posedge clk);
      edges = 0;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      while (((i == 0) ? done0 : done1) !== 1'b1 && edges < 200) begin
         @(posedge clk); edges++;
         @(negedge clk);
      end
      chk("scan_latency", edges, req_edges);
   endtask

   task automatic wait_idx0(input logic [2:0] v);
      int n;
      n = 0;
      while ({in1_0, in2_0, in3_0} !== v && n < 200) begin
         @(negedge clk); n++;
      end
      chk("wait_idx_timeout", {31'd0, n < 200}, 32'd1);
   endtask

   initial begin
      int e;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset_table", {24'd0, tab0}, 32'h00);
      chk("reset_busy",  {31'd0, busy0}, 32'd0);

      // Scan of code 06 with matching expected code.
      fn0 = 8'h06;
      scan(0, 8'h06, 32);
      chk("t1_table", {24'd0, tab0}, 32'h06);
      chk("t1_match", {31'd0, match0}, 32'd1);
      chk("t1_mask",  {24'd0, mask0}, 32'h00);
      chk("t1_bus",   {29'd0, in1_0, in2_0, in3_0}, 32'd0);

      // Same block, expected code 60.
      scan(0, 8'h60, 32);
      chk("t2_table", {24'd0, tab0}, 32'h06);
      chk("t2_match", {31'd0, match0}, 32'd0);
      chk("t2_mask",  {24'd0, mask0}, 32'h66);

      // Block output tied to 1; abort the scan at idx 3.
      fn0 = 8'hFF;
      @(negedge clk); start0 = 1'b1; exp0 = 8'hFF;
      @(negedge clk); start0 = 1'b0;
      wait_idx0(3'd3);
      abort0 = 1'b1;
      @(negedge clk); abort0 = 1'b0;
      chk("t3_busy_after_abort",  {31'd0, busy0}, 32'd0);
      chk("t3_table_after_abort", {24'd0, tab0}, 32'h06);
      repeat (5) begin
         @(negedge clk);
         chk("t3_no_done", {31'd0, done0}, 32'd0);
      end
      scan(0, 8'hFF, 32);
      chk("t3_table", {24'd0, tab0}, 32'hFF);
      chk("t3_match", {31'd0, match0}, 32'd1);

      // start held high: second done lands 2 + 32 edges after the first.
      fn0 = 8'h06;
      @(negedge clk); start0 = 1'b1; exp0 = 8'h06;
      @(posedge clk);
      e = 0;
      @(negedge clk);
      while (done0 !== 1'b1 && e < 200) begin @(posedge clk); e++; @(negedge clk); end
      chk("t4_first_done", e, 32);
      e = 0;
      do begin @(posedge clk); e++; @(negedge clk); end while (done0 !== 1'b1 && e < 200);
      chk("t4_second_done", e, 34);
      start0 = 1'b0;
      repeat (3) @(negedge clk);

      // Reset asserted mid-scan at idx 5.
      @(negedge clk); start0 = 1'b1; exp0 = 8'h06;
      @(negedge clk); start0 = 1'b0;
      wait_idx0(3'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_bus",   {29'd0, in1_0, in2_0, in3_0}, 32'd0);
      chk("t5_busy",  {31'd0, busy0}, 32'd0);
      chk("t5_table", {24'd0, tab0}, 32'h00);
      chk("t5_match", {31'd0, match0}, 32'd0);
      chk("t5_mask",  {24'd0, mask0}, 32'h00);
      @(negedge clk); rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("t5_idle_no_done", {31'd0, done0}, 32'd0);
      end
      scan(0, 8'h06, 32);
      chk("t5_table", {24'd0, tab0}, 32'h06);
      chk("t5_match", {31'd0, match0}, 32'd1);

      // XOR3 with one-cycle settling.
      fn1 = 8'h69;
      scan(1, 8'h69, 8);
      chk("t6_table", {24'd0, tab1}, 32'h69);
      chk("t6_match", {31'd0, match1}, 32'd1);
      chk("t6_mask",  {24'd0, mask1}, 32'h00);

      // Randomised traffic on both instances, checked by the compare process.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         start0 = ($urandom_range(0, 5) == 0);
         start1 = ($urandom_range(0, 3) == 0);
         abort0 = ($urandom_range(0, 79) == 0);
         abort1 = ($urandom_range(0, 19) == 0);
         exp0   = 8'($urandom);
         exp1   = ($urandom_range(0, 1) == 0) ? fn1 : 8'($urandom);
         if ($urandom_range(0, 49) == 0) fn0 = 8'($urandom);
         if ($urandom_range(0, 49) == 0) fn1 = 8'($urandom);
      end
      start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_reader.md
Name: truth_table_reader

Overview:
- Sequential characteriser for 3-input combinational logic blocks such as the mXXXX truth-table modules.
- Works in the opposite direction to those blocks: drives all eight input combinations onto a device under test and samples its output for each one.
- Rebuilds the 8-bit function code (e.g. 0x06) from the samples and compares it against an expected code.
- Sits in the verification/characterisation harness, between a controller and the logic block being measured.

Parameters:
- SETTLE_CYCLES, 4, cycles each input vector is held before the DUT output is sampled; legal values are ≥1.
- CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W ≥ SETTLE_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  scan request; accepted only in IDLE
- abort  input  1  synchronous abort of a scan in progress
- expected  input  8  expected function code; latched when start is accepted
- dut_out  input  1  output of the device under test
- in1  output  1  DUT input, MSB of the vector index
- in2  output  1  DUT input, middle bit of the vector index
- in3  output  1  DUT input, LSB of the vector index
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle completion pulse
- table_out  output  8  reconstructed function code
- match  output  1  high when table_out equals the latched expected code
- mismatch_mask  output  8  table_out XOR latched expected

Behaviour:
- Reset (async assert, sync release): state=IDLE, {in1,in2,in3}=000, busy=0, done=0, table_out=0, match=0, mismatch_mask=0, idx=0, cnt=0, shadow table=0, latched expected=0.
- Code convention: idx={in1,in2,in3}; table bit (7-idx) = DUT output for that vector. So output high at idx 5 and 6 gives 0x06.
- FSM states:
  - IDLE: start=1 → SETTLE, idx=0, cnt=0, busy=1, expected latched, shadow table cleared. Otherwise hold. abort is ignored in IDLE.
  - SETTLE: {in1,in2,in3} is driven from the idx register.
    - cnt increments each cycle.
    - At the edge where cnt==SETTLE_CYCLES-1, dut_out is written into shadow bit (7-idx) and cnt returns to 0.
    - If idx==7 at that edge → DONE; else idx increments.
  - DONE: lasts one cycle. done=1, busy=0. Next edge → IDLE.
- Result timing: table_out, match and mismatch_mask update at the edge that enters DONE, using the full shadow table including the final sample. They hold their values until the next completed scan.
- Latency: the edge that accepts start is edge 0. done is high between edge 8*SETTLE_CYCLES and edge 8*SETTLE_CYCLES+1. Each vector is held for exactly SETTLE_CYCLES cycles.
- Input bus after a scan: {in1,in2,in3} returns to 000 on entry to DONE and stays 000 in IDLE.
- Start handling:
  - start while busy or in the DONE cycle is ignored; it is not queued.
  - start asserted in the cycle after DONE is accepted normally.
- Abort: abort=1 in SETTLE → IDLE at the next edge.
  - busy=0, input bus goes to 000, no done pulse.
  - table_out, match and mismatch_mask keep their previous values.
  - If abort and the final sample edge coincide, abort wins.
- Reset mid-scan: every output returns to its reset value immediately; no done pulse is issued.
- dut_out is sampled raw with no synchroniser. The DUT is on the same clock domain, and SETTLE_CYCLES covers its propagation.
- Counters never wrap:
  - idx stops at 7.
  - cnt is cleared on every vector change and on entry to IDLE.

Test Plan:
1. DUT model = 0x06 function, SETTLE_CYCLES=4, expected=0x06, pulse start → input bus steps 000,001,…,111 with 4 cycles each; done pulses at edge 32; table_out=0x06, match=1, mismatch_mask=0x00; bus returns to 000.
2. Same DUT, expected=0x60 → table_out=0x06, match=0, mismatch_mask=0x66.
3. DUT tied to constant 1 after a 0x06 scan; assert abort while idx=3 → busy falls next cycle, no done pulse, table_out stays 0x06; a fresh scan then yields 0xFF.
4. start held high through a whole scan → exactly one scan and one done pulse while start is high; a second scan begins at the edge after DONE and its done pulse lands 32 edges later.
5. Assert rst_n low at idx=5 mid-scan → all outputs are 0 immediately; after release, an idle hold with no spurious done, then a normal scan completes correctly.
6. SETTLE_CYCLES=1, DUT = XOR3 → each vector is held for one cycle, done at edge 8, table_out=0x69, match=1 with expected=0x69.
